// File: rtl/cmpxchg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmpxchg_ctrl_pkg
//  Description : Shared execute-stage definitions for the CMPXCHG sequencer.
//                It holds the flag bit positions, the operand size encodings
//                and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmpxchg_ctrl_pkg;

    // Flag vector bit positions
    localparam int CF_BIT = 0;
    localparam int PF_BIT = 1;
    localparam int AF_BIT = 2;
    localparam int ZF_BIT = 3;
    localparam int SF_BIT = 4;
    localparam int OF_BIT = 5;

    // Operand size encodings. Encoding 3 is illegal and is handled as 32-bit.
    localparam logic [1:0] SZ8  = 2'd0;
    localparam logic [1:0] SZ16 = 2'd1;
    localparam logic [1:0] SZ32 = 2'd2;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMP   = 3'd1,
        ST_RFWB  = 3'd2,
        ST_MEMWB = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage : cmpxchg_ctrl_pkg
`default_nettype wire

// File: rtl/cmpxchg_ctrl_flagcalc.sv
`default_nettype none
// ============================================================================
//  Module      : cmpxchg_flagcalc
//  Description : Combinational CMP-style flag generator. It computes
//                d = a - b at the selected operand size and derives
//                CF/PF/AF/ZF/SF/OF. Bits above the operand size are ignored.
//  Ports       : a, b  [W-1:0] accumulator and destination operands
//                size  [1:0]   operand size (SZ8/SZ16/SZ32, 3 -> 32-bit)
//                flags [5:0]   {OF,SF,ZF,AF,PF,CF}
//  Revision    : 1.0 - initial release
// ============================================================================
module cmpxchg_flagcalc
    import cmpxchg_ctrl_pkg::*;
#(
    parameter int W = 32    // must be at least 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   size,
    output logic [5:0]   flags
);

    logic [31:0] w_mask;
    logic [31:0] w_a_m;
    logic [31:0] w_b_m;
    logic [31:0] w_d_m;
    logic        w_a_s;
    logic        w_b_s;
    logic        w_d_s;

    always_comb begin
        case (size)
            SZ8:     w_mask = 32'h0000_00FF;
            SZ16:    w_mask = 32'h0000_FFFF;
            default: w_mask = 32'hFFFF_FFFF;
        endcase

        w_a_m = a[31:0] & w_mask;
        w_b_m = b[31:0] & w_mask;
        // Masking the wrapped difference gives the size-width result.
        w_d_m = (w_a_m - w_b_m) & w_mask;

        case (size)
            SZ8: begin
                w_a_s = w_a_m[7];
                w_b_s = w_b_m[7];
                w_d_s = w_d_m[7];
            end
            SZ16: begin
                w_a_s = w_a_m[15];
                w_b_s = w_b_m[15];
                w_d_s = w_d_m[15];
            end
            default: begin
                w_a_s = w_a_m[31];
                w_b_s = w_b_m[31];
                w_d_s = w_d_m[31];
            end
        endcase

        flags         = '0;
        // Borrow out of the size MSB is the unsigned "a below b" condition.
        flags[CF_BIT] = (w_a_m < w_b_m);
        flags[PF_BIT] = ~(^w_d_m[7:0]);
        // Borrow from bit 3 is the unsigned compare of the low nibbles.
        flags[AF_BIT] = (w_a_m[3:0] < w_b_m[3:0]);
        flags[ZF_BIT] = (w_d_m == 32'd0);
        flags[SF_BIT] = w_d_s;
        flags[OF_BIT] = (w_a_s ^ w_b_s) & (w_a_s ^ w_d_s);
    end

    if (W > 32) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^{a[W-1:32], b[W-1:32]};
    end

endmodule : cmpxchg_flagcalc
`default_nettype wire

// File: rtl/cmpxchg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cmpxchg_ctrl
//  Description : Multi-cycle execute-stage sequencer for CMPXCHG. It latches
//                the operands, registers the CMP flags, issues writeback
//                through the register write port or the memory write port,
//                then holds a completion token until retire accepts it.
//  Ports       : clk, reset           clock, synchronous active-high reset
//                in_valid/in_ready    dispatch handshake (ready only in IDLE)
//                in_size, in_dest_mem operand size, memory destination flag
//                in_rm, in_r, in_eax  destination, source, accumulator
//                rf_wr_*              register write port
//                mem_req/mem_wdata    memory write request, held until mem_ack
//                flags_out/out_valid  completion token, out_ready to retire
//  Revision    : 1.0 - initial release
// ============================================================================
module cmpxchg_ctrl
    import cmpxchg_ctrl_pkg::*;
#(
    parameter int W       = 32,
    parameter int FLAGS_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    // dispatch
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_size,
    input  logic               in_dest_mem,
    input  logic [W-1:0]       in_rm,
    input  logic [W-1:0]       in_r,
    input  logic [W-1:0]       in_eax,
    // register write port
    output logic               rf_wr_en,
    output logic               rf_wr_acc,
    output logic [1:0]         rf_wr_size,
    output logic [W-1:0]       rf_wr_data,
    // memory write port
    output logic               mem_req,
    output logic [W-1:0]       mem_wdata,
    input  logic               mem_ack,
    // retire
    output logic [FLAGS_W-1:0] flags_out,
    output logic               out_valid,
    input  logic               out_ready
);

    state_t             r_state;
    logic               r_in_ready;
    logic [1:0]         r_size;
    logic               r_dest_mem;
    logic [W-1:0]       r_rm;
    logic [W-1:0]       r_r;
    logic [W-1:0]       r_eax;
    logic               r_eq;
    logic [FLAGS_W-1:0] r_flags;
    logic               r_rf_wr_en;
    logic               r_rf_wr_acc;
    logic [W-1:0]       r_rf_wr_data;
    logic               r_mem_req;
    logic [W-1:0]       r_mem_wdata;
    logic               r_out_valid;

    logic [5:0]         w_flags;
    logic               w_zf;
    logic               w_mem_rf_wr;

    cmpxchg_flagcalc #(
        .W (W)
    ) u_flagcalc (
        .a     (r_eax),
        .b     (r_rm),
        .size  (r_size),
        .flags (w_flags)
    );

    assign w_zf = w_flags[ZF_BIT];

    // A failed compare on a memory destination also loads the accumulator.
    // That write is pulsed in the ack cycle itself, so it follows mem_ack
    // combinationally. Data and target were already registered in CMP.
    assign w_mem_rf_wr = (r_state == ST_MEMWB) & mem_ack & ~r_eq & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b1;
            r_size       <= 2'd0;
            r_dest_mem   <= 1'b0;
            r_rm         <= '0;
            r_r          <= '0;
            r_eax        <= '0;
            r_eq         <= 1'b0;
            r_flags      <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_acc  <= 1'b0;
            r_rf_wr_data <= '0;
            r_mem_req    <= 1'b0;
            r_mem_wdata  <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_size     <= in_size;
                        r_dest_mem <= in_dest_mem;
                        r_rm       <= in_rm;
                        r_r        <= in_r;
                        r_eax      <= in_eax;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CMP;
                    end
                end

                ST_CMP: begin
                    r_flags      <= w_flags[FLAGS_W-1:0];
                    r_eq         <= w_zf;
                    // On a match the source goes to the destination, otherwise
                    // the destination value goes to the accumulator.
                    r_rf_wr_acc  <= ~w_zf;
                    r_rf_wr_data <= w_zf ? r_r : r_rm;
                    if (r_dest_mem) begin
                        // The memory write always happens, even on a mismatch.
                        r_mem_req   <= 1'b1;
                        r_mem_wdata <= w_zf ? r_r : r_rm;
                        r_state     <= ST_MEMWB;
                    end else begin
                        r_rf_wr_en <= 1'b1;
                        r_state    <= ST_RFWB;
                    end
                end

                ST_RFWB: begin
                    r_rf_wr_en  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end

                ST_MEMWB: begin
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_rf_wr_en  <= 1'b0;
                    r_mem_req   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign rf_wr_en   = r_rf_wr_en | w_mem_rf_wr;
    assign rf_wr_acc  = r_rf_wr_acc;
    assign rf_wr_size = r_size;
    assign rf_wr_data = r_rf_wr_data;
    // An abandoned request is withdrawn in the reset cycle itself.
    assign mem_req    = r_mem_req & ~reset;
    assign mem_wdata  = r_mem_wdata;
    assign flags_out  = r_flags;
    assign out_valid  = r_out_valid;

endmodule : cmpxchg_ctrl
`default_nettype wire

// File: tb/tb_cmpxchg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmpxchg_ctrl
//  Description : Directed self-checking bench for cmpxchg_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmpxchg_ctrl;

    localparam int W       = 32;
    localparam int FLAGS_W = 6;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_size;
    logic               in_dest_mem;
    logic [W-1:0]       in_rm;
    logic [W-1:0]       in_r;
    logic [W-1:0]       in_eax;
    logic               rf_wr_en;
    logic               rf_wr_acc;
    logic [1:0]         rf_wr_size;
    logic [W-1:0]       rf_wr_data;
    logic               mem_req;
    logic [W-1:0]       mem_wdata;
    logic               mem_ack;
    logic [FLAGS_W-1:0] flags_out;
    logic               out_valid;
    logic               out_ready;

    int n_cmp;
    int n_err;
    int n_rf;

    cmpxchg_ctrl #(
        .W       (W),
        .FLAGS_W (FLAGS_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_size     (in_size),
        .in_dest_mem (in_dest_mem),
        .in_rm       (in_rm),
        .in_r        (in_r),
        .in_eax      (in_eax),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_acc   (rf_wr_acc),
        .rf_wr_size  (rf_wr_size),
        .rf_wr_data  (rf_wr_data),
        .mem_req     (mem_req),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .flags_out   (flags_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count register write strobes seen at the active edge.
    always @(posedge clk) begin
        if (rf_wr_en) n_rf = n_rf + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation in IDLE and returns in the CMP cycle.
    task automatic start_op(input logic [1:0] sz, input logic dm,
                            input logic [31:0] rm, input logic [31:0] r,
                            input logic [31:0] eax);
        in_valid    = 1'b1;
        in_size     = sz;
        in_dest_mem = dm;
        in_rm       = rm;
        in_r        = r;
        in_eax      = eax;
        check_val("start_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_val("cmp_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("cmp_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    endtask

    // Accepts the token in RESP and checks the return to IDLE.
    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("ret_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("ret_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic reg_op(input logic [1:0] sz, input logic [31:0] rm,
                          input logic [31:0] r, input logic [31:0] eax,
                          input logic exp_acc, input logic [31:0] exp_data,
                          input logic [5:0] exp_flags);
        int rf0;
        rf0 = n_rf;
        start_op(sz, 1'b0, rm, r, eax);
        tick();
        check_val("rfwb_en", {31'd0, rf_wr_en}, 32'd1);
        check_val("rfwb_acc", {31'd0, rf_wr_acc}, {31'd0, exp_acc});
        check_val("rfwb_data", rf_wr_data, exp_data);
        check_val("rfwb_size", {30'd0, rf_wr_size}, {30'd0, sz});
        check_val("rfwb_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rfwb_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check_val("resp_out_valid", {31'd0, out_valid}, 32'd1);
        check_val("resp_flags", {26'd0, flags_out}, {26'd0, exp_flags});
        check_val("resp_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check_val("resp_in_ready", {31'd0, in_ready}, 32'd0);
        retire();
        check_val("reg_rf_pulses", n_rf - rf0, 32'd1);
    endtask

    task automatic mem_op(input logic [1:0] sz, input logic [31:0] rm,
                          input logic [31:0] r, input logic [31:0] eax,
                          input int ack_delay, input logic exp_rf,
                          input logic [31:0] exp_wdata, input logic [5:0] exp_flags);
        int rf0;
        rf0 = n_rf;
        start_op(sz, 1'b1, rm, r, eax);
        check_val("cmp_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        for (int i = 0; i < ack_delay; i++) begin
            check_val("wait_mem_req", {31'd0, mem_req}, 32'd1);
            check_val("wait_mem_wdata", mem_wdata, exp_wdata);
            check_val("wait_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
            check_val("wait_out_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        mem_ack = 1'b1;
        #1;
        check_val("ack_mem_req", {31'd0, mem_req}, 32'd1);
        check_val("ack_mem_wdata", mem_wdata, exp_wdata);
        check_val("ack_rf_wr_en", {31'd0, rf_wr_en}, {31'd0, exp_rf});
        if (exp_rf) begin
            check_val("ack_rf_acc", {31'd0, rf_wr_acc}, 32'd1);
            check_val("ack_rf_data", rf_wr_data, rm);
        end
        tick();
        mem_ack = 1'b0;
        check_val("post_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("post_out_valid", {31'd0, out_valid}, 32'd1);
        check_val("post_flags", {26'd0, flags_out}, {26'd0, exp_flags});
        check_val("post_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
        retire();
        check_val("mem_rf_pulses", n_rf - rf0, exp_rf ? 32'd1 : 32'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        n_rf        = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_size     = 2'd0;
        in_dest_mem = 1'b0;
        in_rm       = '0;
        in_r        = '0;
        in_eax      = '0;
        mem_ack     = 1'b0;
        out_ready   = 1'b0;
        tick();
        tick();

        // Reset state
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_flags", {26'd0, flags_out}, 32'd0);
        check_val("rst_rf_wr_data", rf_wr_data, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        check_val("rst_rf_wr_size", {30'd0, rf_wr_size}, 32'd0);
        reset = 1'b0;
        tick();

        // 32-bit equal, register destination: write r to rm, ZF|PF.
        reg_op(2'd2, 32'h1234_5678, 32'hCAFE_F00D, 32'h1234_5678,
               1'b0, 32'hCAFE_F00D, 6'b001010);

        // 32-bit 1 - 2: CF, PF, AF, SF set; accumulator gets rm.
        reg_op(2'd2, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0000_0001,
               1'b1, 32'h0000_0002, 6'b010111);

        // 8-bit 0x80 - 0x01 = 0x7F, memory destination, ack after 3 cycles:
        // OF and AF set, odd parity, write back rm to memory and accumulator.
        mem_op(2'd0, 32'h0000_0001, 32'h5555_AAAA, 32'hFFFF_FF80,
               3, 1'b1, 32'h0000_0001, 6'b100100);

        // 16-bit equal, memory destination, ack with the first request cycle.
        mem_op(2'd1, 32'h0000_BEEF, 32'h1357_9BDF, 32'h0000_BEEF,
               0, 1'b0, 32'h1357_9BDF, 6'b001010);

        // Illegal size 3 compares as 32-bit: upper bits differ, so no match.
        reg_op(2'd3, 32'h1000_0000, 32'h0000_0042, 32'h2000_0000,
               1'b1, 32'h1000_0000, 6'b000010);

        // Retire back-pressure with a competing offer. 16-bit 0x8000 - 0x0001
        // = 0x7FFF (upper eax bits ignored): OF, AF, PF set.
        start_op(2'd1, 1'b0, 32'h0000_0001, 32'h0000_0077, 32'h1234_8000);
        tick();
        check_val("bp_rfwb_acc", {31'd0, rf_wr_acc}, 32'd1);
        check_val("bp_rfwb_data", rf_wr_data, 32'h0000_0001);
        tick();
        in_valid    = 1'b1;
        in_size     = 2'd2;
        in_dest_mem = 1'b0;
        in_rm       = 32'h0000_0005;
        in_r        = 32'h0000_0009;
        in_eax      = 32'h0000_0005;
        for (int i = 0; i < 4; i++) begin
            check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_flags", {26'd0, flags_out}, 32'b100110);
            check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check_val("bp_accept", {31'd0, in_ready}, 32'd0);
        tick();
        check_val("bp2_rf_acc", {31'd0, rf_wr_acc}, 32'd0);
        check_val("bp2_rf_data", rf_wr_data, 32'h0000_0009);
        tick();
        check_val("bp2_flags", {26'd0, flags_out}, 32'b001010);
        retire();

        // Reset while the memory write is outstanding.
        start_op(2'd2, 1'b1, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007);
        tick();
        check_val("mrst_mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("mrst_drop_now", {31'd0, mem_req}, 32'd0);
        tick();
        reset = 1'b0;
        check_val("mrst_mem_req_after", {31'd0, mem_req}, 32'd0);
        check_val("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("mrst_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
        tick();
        check_val("mrst_out_valid2", {31'd0, out_valid}, 32'd0);
        check_val("mrst_mem_req2", {31'd0, mem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cmpxchg_ctrl
`default_nettype wire
